// File: rtl/tx_burst_sched_if.sv
// Settings bus and burst-descriptor handshake between the buffer-pool TX controller and tx_burst_sched.
interface tx_burst_sched_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_time;
    logic [15:0] desc_len;
    logic [2:0]  desc_flags;

    modport master (
        output set_stb, set_addr, set_data,
        output desc_valid, desc_time, desc_len, desc_flags,
        input  desc_ready
    );

    modport slave (
        input  set_stb, set_addr, set_data,
        input  desc_valid, desc_time, desc_len, desc_flags,
        output desc_ready
    );
endinterface

// File: rtl/tx_burst_sched.sv
// Timed TX burst scheduler: queues descriptors and gates DSP strobes once master_time reaches each burst time.
// Optional macro TX_SCHED_STATS_EN adds saturating sent/late counters on the stats port and in debug[31:16].
module tx_burst_sched #(
    parameter int BASE       = 128,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    tx_burst_sched_if.slave   bus,
    input  logic [31:0]       master_time,
    input  logic              strobe_in,
    output logic              strobe_o,
    output logic              run_o,
    output logic              drain_o,
    input  logic              drain_rdy,
    input  logic              underrun_in,
    output logic              late,
    output logic              halted,
`ifdef TX_SCHED_STATS_EN
    output logic [31:0]       stats,
`endif
    output logic [31:0]       debug
);
    localparam int                  DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [7:0]          ADDR_CTRL   = 8'(BASE);
    localparam logic [7:0]          ADDR_POLICY = 8'(BASE + 1);
    localparam logic [4:0]          TAIL_CYCLES = 5'd16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TIME = 3'd1,
        RUN       = 3'd2,
        DRAIN     = 3'd3,
        HALT      = 3'd7
    } state_t;

    typedef struct packed {
        logic [31:0] t;
        logic [15:0] len;
        logic [2:0]  flags;
    } desc_t;

    desc_t                 fifo_q [DEPTH];
    desc_t                 head;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    state_t      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] work_time_q, work_time_d;
    logic [2:0]  work_flags_q, work_flags_d;
    logic [4:0]  tail_q, tail_d;
    logic        enable_q, enable_d;
    logic        late_policy_q, late_policy_d;
    logic        run_q, run_d;
    logic        late_q, late_d;
    logic        halted_q, halted_d;

    logic        ctrl_wr, policy_wr, clear;
    logic        full, empty, push, pop, sent;
    logic [31:0] diff;
    logic        unused_bits;

`ifdef TX_SCHED_STATS_EN
    logic [15:0] bursts_sent_q, bursts_sent_d;
    logic [15:0] bursts_late_q, bursts_late_d;
`endif

    assign ctrl_wr   = bus.set_stb && (bus.set_addr == ADDR_CTRL);
    assign policy_wr = bus.set_stb && (bus.set_addr == ADDR_POLICY);
    assign clear     = ctrl_wr && bus.set_data[1];

    // A push arriving on a full FIFO is refused even if a pop frees a slot in the same cycle.
    assign full           = (count_q == FULL_COUNT);
    assign empty          = (count_q == '0);
    assign bus.desc_ready = !full;
    assign push           = bus.desc_valid && !full;
    assign head           = fifo_q[rd_ptr_q];
    assign diff           = work_time_q - master_time;

    assign unused_bits = ^{bus.set_data[31:2], work_flags_q[2]};

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        work_time_d   = work_time_q;
        work_flags_d  = work_flags_q;
        tail_d        = (tail_q != 5'd0) ? tail_q - 5'd1 : 5'd0;
        enable_d      = ctrl_wr ? bus.set_data[0] : enable_q;
        late_policy_d = policy_wr ? bus.set_data[0] : late_policy_q;
        late_d        = 1'b0;
        pop           = 1'b0;
        sent          = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_q && !empty) begin
                    pop          = 1'b1;
                    work_time_d  = head.t;
                    work_flags_d = head.flags;
                    remaining_d  = head.len;
                    if (head.len != 16'd0) begin
                        state_d = WAIT_TIME;
                    end
                end
            end
            WAIT_TIME: begin
                if (work_flags_q[0] || !work_flags_q[1] || diff == 32'd0) begin
                    state_d = RUN;
                end else if (diff[31]) begin
                    if (late_policy_q) begin
                        state_d = RUN;
                    end else begin
                        late_d  = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                if (strobe_in) begin
                    remaining_d = remaining_q - 16'd1;
                end
                // Underrun wins over the completing strobe.
                if (underrun_in) begin
                    state_d = HALT;
                    tail_d  = 5'd0;
                end else if (strobe_in && remaining_q == 16'd1) begin
                    state_d = IDLE;
                    tail_d  = TAIL_CYCLES;
                    sent    = 1'b1;
                end
            end
            DRAIN: begin
                if (remaining_q == 16'd0) begin
                    state_d = IDLE;
                end else if (drain_rdy) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                tail_d = 5'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d     = IDLE;
            remaining_d = 16'd0;
            tail_d      = 5'd0;
            late_d      = 1'b0;
            pop         = 1'b0;
            sent        = 1'b0;
        end

        halted_d = (state_d == HALT);
        run_d    = (state_d == RUN) || (tail_d != 5'd0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_comb begin
        bursts_sent_d = bursts_sent_q;
        bursts_late_d = bursts_late_q;
        if (sent && bursts_sent_q != 16'hFFFF) begin
            bursts_sent_d = bursts_sent_q + 16'd1;
        end
        if (late_d && bursts_late_q != 16'hFFFF) begin
            bursts_late_d = bursts_late_q + 16'd1;
        end
        if (clear) begin
            bursts_sent_d = 16'd0;
            bursts_late_d = 16'd0;
        end
    end
`endif

    // Descriptor storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fifo_q[wr_ptr_q] <= '{t: bus.desc_time, len: bus.desc_len, flags: bus.desc_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            remaining_q   <= 16'd0;
            work_time_q   <= 32'd0;
            work_flags_q  <= 3'd0;
            tail_q        <= 5'd0;
            enable_q      <= 1'b0;
            late_policy_q <= 1'b0;
            run_q         <= 1'b0;
            late_q        <= 1'b0;
            halted_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
`ifdef TX_SCHED_STATS_EN
            bursts_sent_q <= 16'd0;
            bursts_late_q <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            work_time_q   <= work_time_d;
            work_flags_q  <= work_flags_d;
            tail_q        <= tail_d;
            enable_q      <= enable_d;
            late_policy_q <= late_policy_d;
            run_q         <= run_d;
            late_q        <= late_d;
            halted_q      <= halted_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
`ifdef TX_SCHED_STATS_EN
            bursts_sent_q <= bursts_sent_d;
            bursts_late_q <= bursts_late_d;
`endif
        end
    end

    assign strobe_o = (state_q == RUN) && strobe_in;
    assign drain_o  = (state_q == DRAIN) && drain_rdy && (remaining_q != 16'd0);
    assign run_o    = run_q;
    assign late     = late_q;
    assign halted   = halted_q;

`ifdef TX_SCHED_STATS_EN
    assign stats = {bursts_late_q, bursts_sent_q};
    assign debug = {bursts_sent_q, remaining_q[11:0], 1'b0, state_q};
`else
    assign debug = {16'b0, remaining_q[11:0], 1'b0, state_q};
`endif
endmodule
